ifu: RTL

Instruction fetch unit for the NPC single-cycle RV32 core. Owns the program counter, fetches one 32-bit word per instruction over a valid/ready request / valid response memory port, and presents it with its PC to the decode/execute datapath through a valid/ready handshake. Accepts PC redirects (jalr, future branches) from the datapath and a halt request driven by ebreak.

---
 rtl/ifu.sv | 125 ++++++++++++
 1 files changed

// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, issues one word fetch per
// instruction and hands it to the datapath over valid/ready.
module ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic [31:0] fetch_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } state_t;

  state_t      state;
  state_t      state_nxt;
  state_t      resume;
  logic [31:0] pc;
  logic [31:0] pc_nxt;
  logic [31:0] rd_pc;
  logic        flush;
  logic        flush_nxt;
  logic        load;
  logic        inst_hs;

  assign rd_pc   = {redirect_pc[31:2], 2'b00};
  assign resume  = halt ? IDLE : REQ;
  assign inst_hs = (state == HOLD) && inst_ready;

  // State, PC and delivered-instruction registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= REQ;
      pc        <= RESET_PC;
      flush     <= 1'b0;
      inst      <= '0;
      inst_pc   <= '0;
      fetch_cnt <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      flush <= flush_nxt;
      if (load) begin
        inst    <= imem_resp_data;
        inst_pc <= pc;
      end
      if (inst_hs)
        fetch_cnt <= fetch_cnt + 32'd1;
    end
  end

  // Next state: a redirect always retargets pc; one that lands on an
  // accepted request marks its response stale via flush
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    flush_nxt = flush;
    load      = 1'b0;
    unique case (state)
      IDLE: begin
        if (redirect_valid)
          pc_nxt = rd_pc;
        if (!halt)
          state_nxt = REQ;
      end
      REQ: begin
        if (redirect_valid)
          pc_nxt = rd_pc;
        if (imem_req_ready) begin
          state_nxt = WAIT;
          flush_nxt = redirect_valid;
        end else if (halt) begin
          state_nxt = IDLE;
        end
      end
      WAIT: begin
        if (redirect_valid)
          pc_nxt = rd_pc;
        if (imem_resp_valid) begin
          if (flush || redirect_valid) begin
            flush_nxt = 1'b0;
            state_nxt = resume;
          end else begin
            load      = 1'b1;
            state_nxt = HOLD;
          end
        end else if (redirect_valid) begin
          flush_nxt = 1'b1;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_nxt    = rd_pc;
          state_nxt = resume;
        end else if (inst_ready) begin
          pc_nxt    = pc + 32'd4;
          state_nxt = resume;
        end
      end
    endcase
  end

  // Outputs depend on registered state only
  always_comb begin
    imem_req_valid = (state == REQ);
    imem_req_addr  = pc;
    inst_valid     = (state == HOLD);
  end

endmodule
